// File: rtl/irq_handshake_pkg.sv
// Shared types and default sizes for the core interrupt handshake stage.
package irq_handshake_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CLEAR = 2'd2,
        GUARD = 2'd3
    } state_t;

    localparam int NB_LINES_DEF = 32;
    localparam int ID_WIDTH_DEF = 5;
    localparam int CNT_WIDTH    = 16;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder; same priority order as the upstream unit.
module irq_prio_enc #(
    parameter int NB_LINES = 32,
    parameter int ID_WIDTH = 5
) (
    input  logic [NB_LINES-1:0] req,
    output logic [ID_WIDTH-1:0] id,
    output logic                valid
);

    // first_hot keeps only the lowest set bit, so the id OR-reduction below is exact.
    logic [NB_LINES-1:0] lower_any;
    logic [NB_LINES-1:0] first_hot;

    assign lower_any[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NB_LINES; gi++) begin : g_lower
            assign lower_any[gi] = lower_any[gi-1] | req[gi-1];
        end
        for (gi = 0; gi < NB_LINES; gi++) begin : g_first
            assign first_hot[gi] = req[gi] & ~lower_any[gi];
        end
    endgenerate

    always_comb begin
        id = '0;
        for (int i = 0; i < NB_LINES; i++) begin
            if (first_hot[i]) begin
                id = id | ID_WIDTH'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/irq_core_handshake.sv
// Presents one registered request + id to the core, runs the req/ack handshake and
// retires the serviced line with a one-cycle one-hot clear pulse toward the service unit.
module irq_core_handshake
    import irq_handshake_pkg::*;
#(
    parameter int NB_LINES     = NB_LINES_DEF,
    parameter int ID_WIDTH     = ID_WIDTH_DEF,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NB_LINES-1:0]  irq_req_i,
    input  logic                 core_irq_en_i,
    output logic                 core_irq_o,
    output logic [ID_WIDTH-1:0]  core_irq_id_o,
    input  logic                 core_irq_ack_i,
    input  logic [ID_WIDTH-1:0]  core_irq_ack_id_i,
    output logic [NB_LINES-1:0]  clear_o,
    output logic                 ack_err_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] serviced_cnt_o
);

    localparam int GW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);

    state_t                state_reg, state_next;
    logic [ID_WIDTH-1:0]   id_reg, id_next;
    logic [GW-1:0]         guard_reg, guard_next;
    logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
    logic                  irq_reg, irq_next;
    logic [NB_LINES-1:0]   clear_reg, clear_next;
    logic                  err_reg, err_next;
    logic                  busy_reg, busy_next;

    logic [ID_WIDTH-1:0]   enc_id;
    logic                  enc_valid;
    logic                  ack_ok;

    irq_prio_enc #(
        .NB_LINES (NB_LINES),
        .ID_WIDTH (ID_WIDTH)
    ) u_prio_enc (
        .req   (irq_req_i),
        .id    (enc_id),
        .valid (enc_valid)
    );

    assign ack_ok = core_irq_ack_i && (state_reg == REQ) && (core_irq_ack_id_i == id_reg);

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        guard_next = guard_reg;
        cnt_next   = cnt_reg;
        clear_next = '0;
        // Holding err_reg off keeps the pulse single-cycle even if ack is held high.
        err_next   = core_irq_ack_i && !ack_ok && !err_reg;

        unique case (state_reg)
            IDLE: begin
                if (core_irq_en_i && enc_valid) begin
                    state_next = REQ;
                    id_next    = enc_id;
                end
            end
            REQ: begin
                if (ack_ok) begin
                    state_next = CLEAR;
                    clear_next = NB_LINES'(1) << id_reg;
                    if (cnt_reg != '1) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else if (core_irq_ack_i) begin
                    state_next = REQ;
                end else if (!irq_req_i[id_reg] || !core_irq_en_i) begin
                    state_next = IDLE;
                end
            end
            CLEAR: begin
                if (GUARD_CYCLES == 0) begin
                    state_next = IDLE;
                end else begin
                    guard_next = GW'(GUARD_CYCLES);
                    state_next = GUARD;
                end
            end
            GUARD: begin
                // Gives the upstream clear time to land so the same line is not re-raised.
                if (guard_reg <= GW'(1)) begin
                    state_next = IDLE;
                end else begin
                    guard_next = guard_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        irq_next  = (state_next == REQ);
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_reg <= IDLE;
            id_reg    <= '0;
            guard_reg <= '0;
            cnt_reg   <= '0;
            irq_reg   <= 1'b0;
            clear_reg <= '0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
            guard_reg <= guard_next;
            cnt_reg   <= cnt_next;
            irq_reg   <= irq_next;
            clear_reg <= clear_next;
            err_reg   <= err_next;
            busy_reg  <= busy_next;
        end
    end

    assign core_irq_o     = irq_reg;
    assign core_irq_id_o  = id_reg;
    assign clear_o        = clear_reg;
    assign ack_err_o      = err_reg;
    assign busy_o         = busy_reg;
    assign serviced_cnt_o = cnt_reg;

endmodule

// File: tb/tb_irq_core_handshake.sv
// Directed bench for irq_core_handshake; clear pulses are checked against a scoreboard queue.
module tb_irq_core_handshake;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] irq;
    logic        en;
    logic        ack;
    logic [4:0]  ack_id;
    logic        core_irq;
    logic [4:0]  core_id;
    logic [31:0] clear;
    logic        ack_err;
    logic        busy;
    logic [15:0] cnt;

    logic [31:0] irq0;
    logic        en0;
    logic        ack0;
    logic [4:0]  ack_id0;
    logic        core_irq0;
    logic [4:0]  core_id0;
    logic [31:0] clear0;
    logic        ack_err0;
    logic        busy0;
    logic [15:0] cnt0;

    int total = 0;
    int bad   = 0;
    logic [31:0] clr_q[$];
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    irq_core_handshake #(.GUARD_CYCLES(2)) dut (
        .HCLK              (clk),
        .HRESETn           (rstn),
        .irq_req_i         (irq),
        .core_irq_en_i     (en),
        .core_irq_o        (core_irq),
        .core_irq_id_o     (core_id),
        .core_irq_ack_i    (ack),
        .core_irq_ack_id_i (ack_id),
        .clear_o           (clear),
        .ack_err_o         (ack_err),
        .busy_o            (busy),
        .serviced_cnt_o    (cnt)
    );

    irq_core_handshake #(.GUARD_CYCLES(0)) dut0 (
        .HCLK              (clk),
        .HRESETn           (rstn),
        .irq_req_i         (irq0),
        .core_irq_en_i     (en0),
        .core_irq_o        (core_irq0),
        .core_irq_id_o     (core_id0),
        .core_irq_ack_i    (ack0),
        .core_irq_ack_id_i (ack_id0),
        .clear_o           (clear0),
        .ack_err_o         (ack_err0),
        .busy_o            (busy0),
        .serviced_cnt_o    (cnt0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; any clear pulse from the main DUT is matched against the scoreboard.
    task automatic tick();
        logic [31:0] exp_clr;
        @(posedge clk);
        #1;
        if (clear !== 32'h0) begin
            exp_clr = (clr_q.size() == 0) ? 32'h0 : clr_q.pop_front();
            chk("sb_clear", clear, exp_clr);
        end
    endtask

    task automatic send_ack(input logic [4:0] id, input logic [31:0] exp_clr);
        ack    = 1'b1;
        ack_id = id;
        if (exp_clr != 32'h0) clr_q.push_back(exp_clr);
    endtask

    initial begin
        rstn = 1'b0; irq = '0; en = 1'b0; ack = 1'b0; ack_id = '0;
        irq0 = '0; en0 = 1'b0; ack0 = 1'b0; ack_id0 = '0;
        exp_cnt = 16'd0;
        tick(); tick();
        chk("rst_irq", {31'd0, core_irq}, 32'd0);
        chk("rst_id", {27'd0, core_id}, 32'd0);
        chk("rst_clear", clear, 32'd0);
        chk("rst_err", {31'd0, ack_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {16'd0, cnt}, 32'd0);
        rstn = 1'b1;
        tick();

        // 1: single line, latency and guard length
        irq = 32'h10; en = 1'b1;
        chk("t1_pre_irq", {31'd0, core_irq}, 32'd0);
        tick();
        chk("t1_irq", {31'd0, core_irq}, 32'd1);
        chk("t1_id", {27'd0, core_id}, 32'd4);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send_ack(5'd4, 32'h10); exp_cnt++;
        tick();
        ack = 1'b0; irq = '0;
        chk("t1_clear", clear, 32'h10);
        chk("t1_irq_off", {31'd0, core_irq}, 32'd0);
        chk("t1_cnt", {16'd0, cnt}, {16'd0, exp_cnt});
        tick();
        chk("t1_clear_1cyc", clear, 32'h0);
        chk("t1_busy_g1", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_busy_g2", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_busy_idle", {31'd0, busy}, 32'd0);

        // 2: multi-hot, lowest index first, line held until upstream clear lands
        irq = 32'h0000_0806;
        tick();
        chk("t2_id1", {27'd0, core_id}, 32'd1);
        send_ack(5'd1, 32'h2); exp_cnt++;
        tick();
        ack = 1'b0;
        chk("t2_clear1", clear, 32'h2);
        tick(); tick();
        irq = 32'h0000_0804;
        tick();
        chk("t2_no_rearb", {31'd0, core_irq}, 32'd0);
        tick();
        chk("t2_irq2", {31'd0, core_irq}, 32'd1);
        chk("t2_id2", {27'd0, core_id}, 32'd2);
        send_ack(5'd2, 32'h4); exp_cnt++;
        tick();
        ack = 1'b0;
        tick(); tick();
        irq = 32'h0000_0800;
        tick(); tick();
        chk("t2_id11", {27'd0, core_id}, 32'd11);
        send_ack(5'd11, 32'h800); exp_cnt++;
        tick();
        ack = 1'b0; irq = '0;
        chk("t2_clear11", clear, 32'h800);
        tick(); tick(); tick();
        chk("t2_cnt", {16'd0, cnt}, {16'd0, exp_cnt});

        // 3: wrong-id ack, then correct ack
        irq = 32'h10;
        tick();
        send_ack(5'd5, 32'h0);
        tick();
        chk("t3_err", {31'd0, ack_err}, 32'd1);
        chk("t3_irq_held", {31'd0, core_irq}, 32'd1);
        chk("t3_no_clear", clear, 32'h0);
        ack = 1'b0;
        tick();
        chk("t3_err_off", {31'd0, ack_err}, 32'd0);
        send_ack(5'd4, 32'h10); exp_cnt++;
        tick();
        ack = 1'b0; irq = '0;
        chk("t3_clear", clear, 32'h10);
        tick(); tick(); tick();

        // 4: withdrawal, and withdrawal coinciding with a valid ack
        irq = 32'h10;
        tick();
        irq = '0;
        tick();
        chk("t4_withdraw_irq", {31'd0, core_irq}, 32'd0);
        chk("t4_withdraw_clr", clear, 32'h0);
        chk("t4_withdraw_busy", {31'd0, busy}, 32'd0);
        irq = 32'h10;
        tick();
        irq = '0;
        send_ack(5'd4, 32'h10); exp_cnt++;
        tick();
        ack = 1'b0;
        chk("t4_ack_wins", clear, 32'h10);
        tick(); tick(); tick();
        send_ack(5'd0, 32'h0);
        tick();
        ack = 1'b0;
        chk("t4_idle_ack_err", {31'd0, ack_err}, 32'd1);
        chk("t4_idle_busy", {31'd0, busy}, 32'd0);
        chk("t4_cnt", {16'd0, cnt}, {16'd0, exp_cnt});

        // 5: global enable gating, reset during REQ
        en = 1'b0; irq = 32'h1;
        tick(); tick();
        chk("t5_masked", {31'd0, core_irq}, 32'd0);
        en = 1'b1;
        tick();
        chk("t5_irq", {31'd0, core_irq}, 32'd1);
        chk("t5_id0", {27'd0, core_id}, 32'd0);
        rstn = 1'b0;
        tick();
        chk("t5_rst_irq", {31'd0, core_irq}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_clear", clear, 32'h0);
        chk("t5_rst_cnt", {16'd0, cnt}, 32'd0);
        rstn = 1'b1; irq = '0;
        tick();

        // 6: saturating serviced counter
        force dut.cnt_reg = 16'hFFFE;
        tick();
        release dut.cnt_reg;
        exp_cnt = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            irq = 32'h1;
            tick();
            send_ack(5'd0, 32'h1);
            if (exp_cnt != 16'hFFFF) exp_cnt++;
            tick();
            ack = 1'b0; irq = '0;
            chk("t6_sat_cnt", {16'd0, cnt}, {16'd0, exp_cnt});
            tick(); tick(); tick();
        end

        // GUARD_CYCLES=0 build returns to IDLE straight after CLEAR
        en0 = 1'b1; irq0 = 32'h4;
        tick();
        chk("g0_irq", {31'd0, core_irq0}, 32'd1);
        chk("g0_id", {27'd0, core_id0}, 32'd2);
        ack0 = 1'b1; ack_id0 = 5'd2;
        tick();
        ack0 = 1'b0;
        chk("g0_clear", clear0, 32'h4);
        chk("g0_busy_clear", {31'd0, busy0}, 32'd1);
        tick();
        chk("g0_busy_idle", {31'd0, busy0}, 32'd0);
        irq0 = '0;
        tick();

        chk("sb_empty", clr_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
